mac_frame_sequencer: RTL and testbench
======================================

Name: mac_frame_sequencer

Overview:
Upstream control and feed stage for the generic MAC unit. It buffers incoming operand pairs in a small FIFO and, on a start pulse, clears the accumulator. It then streams exactly ACC_CYCLES pairs to the MAC, each with a one-cycle newData strobe. After the MAC latency it captures the accumulated result into a held output register with a one-cycle valid pulse.

Parameters:
BITWIDTH_A, 8, operand A width
BITWIDTH_B, 8, operand B width
ACC_CYCLES, 400, pairs per frame (>=1)
BITWIDTH_ACC, 25, accumulator result width
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)
MAC_LAT, 2, cycles from last newData strobe to a stable MAC AccResult (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle frame start request
in_valid  in  1  operand pair offered
in_a  in  BITWIDTH_A  operand A
in_b  in  BITWIDTH_B  operand B
in_ready  out  1  FIFO can accept (= !full)
mac_clear  out  1  drives MAC reset (active-high)
mac_new_data  out  1  drives MAC newData strobe
mac_operand_a  out  BITWIDTH_A  drives MAC operandA
mac_operand_b  out  BITWIDTH_B  drives MAC operandB
mac_acc_result  in  BITWIDTH_ACC  MAC AccResult
result  out  BITWIDTH_ACC  captured frame result, held until next capture
result_valid  out  1  one-cycle pulse on capture
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async): FSM=IDLE; FIFO empty; count=0.
  - All outputs 0, except in_ready=1 once reset is released.
- FIFO:
  - A push occurs when in_valid && in_ready.
  - A pop occurs only in STREAM when the FIFO is not empty.
  - No bypass: a word pushed in cycle N can pop no earlier than N+1.
  - Push and pop in the same cycle are legal. When full, in_ready=0 that cycle; space freed by a pop is visible the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
  - The FIFO accepts data in every state, including IDLE (prefill allowed).
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
  - IDLE: start=1 -> CLEAR. Otherwise stay.
  - CLEAR: mac_clear=1 for exactly this one cycle; count<=0 -> STREAM.
  - STREAM, each cycle:
    - If the FIFO is not empty: pop; register the popped pair onto mac_operand_a/b; mac_new_data=1 in the following cycle, aligned with the operands.
    - If the FIFO is empty: mac_new_data=0 and count holds (stall; no timeout).
    - On the pop that makes count==ACC_CYCLES -> DRAIN.
  - DRAIN: wait counter starts after the final strobe cycle. After MAC_LAT cycles -> DONE.
  - DONE: result<=mac_acc_result; result_valid=1 for this cycle -> IDLE.
- Operand outputs:
  - mac_operand_a/b hold their last value when no strobe is issued.
  - mac_new_data is never high in two cycles carrying the same pair.
- Latency:
  - With the FIFO prefilled, strobes occupy ACC_CYCLES consecutive cycles.
  - result_valid rises 1 (CLEAR) + 1 (operand register) + ACC_CYCLES + MAC_LAT + 1 cycles after start.
- start while busy=1 is ignored, with no queuing.
- Extra pushed pairs beyond a frame remain in the FIFO for the next frame.
- Widths:
  - count is clog2(ACC_CYCLES+1) bits.
  - result is taken verbatim from the MAC; no truncation or saturation here.
- Reset mid-frame: abort immediately to IDLE and discard FIFO contents. result and result_valid return to 0.
- Simultaneous start and the last pop of a frame cannot occur, because start is only sampled in IDLE.

Test Plan:
- Reset then idle, with ACC_CYCLES=4, MAC_LAT=2 -> in_ready=1; busy, mac_clear, mac_new_data, result_valid all 0; result=0.
- Prefill pairs (1,2),(3,4),(5,6),(7,8), then start; MAC model accumulates -> mac_clear pulses 1 cycle, then 4 consecutive strobes; result_valid once with result=100, 9 cycles after start.
- Start with empty FIFO; push pairs with 3-cycle gaps -> one strobe per pair, busy held high throughout, final result correct, no duplicate strobes.
- Push 6 pairs while IDLE with FIFO_DEPTH=4 -> in_ready=0 after the 4th push; pairs 5–6 accepted only as STREAM pops; pairs 5–6 remain for the second frame.
- Pulse start again during STREAM -> ignored: exactly one mac_clear and one result_valid per frame.
- Assert reset low after 2 strobes -> all outputs 0 asynchronously; FIFO empty; a new frame after release produces the correct result from fresh data only.

Source files
------------

// File: rtl/mac_frame_sequencer.sv
// Purpose: buffers operand pairs and feeds one ACC_CYCLES-long frame per start into a MAC, then captures its result.
// Latency: result_valid rises 1 + 1 + ACC_CYCLES + MAC_LAT + 1 cycles after start when the FIFO is prefilled.
// Backpressure: in_ready drops while the FIFO is full; an empty FIFO stalls the stream with no timeout.
module mac_frame_sequencer #(
  parameter int BITWIDTH_A   = 8,
  parameter int BITWIDTH_B   = 8,
  parameter int ACC_CYCLES   = 400,
  parameter int BITWIDTH_ACC = 25,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAC_LAT      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [BITWIDTH_A-1:0]   in_a,
  input  logic [BITWIDTH_B-1:0]   in_b,
  output logic                    in_ready,
  output logic                    mac_clear,
  output logic                    mac_new_data,
  output logic [BITWIDTH_A-1:0]   mac_operand_a,
  output logic [BITWIDTH_B-1:0]   mac_operand_b,
  input  logic [BITWIDTH_ACC-1:0] mac_acc_result,
  output logic [BITWIDTH_ACC-1:0] result,
  output logic                    result_valid,
  output logic                    busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = $clog2(ACC_CYCLES + 1);
  localparam int WW = $clog2(MAC_LAT + 1);
  localparam int DW = BITWIDTH_A + BITWIDTH_B;
  localparam logic [CW-1:0] LAST_CNT = CW'(ACC_CYCLES - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(MAC_LAT);
  localparam logic [OW-1:0] FULL_OCC = OW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  logic          full, empty, push, pop, capture;

  assign full     = (occ == FULL_OCC);
  assign empty    = (occ == '0);
  // Held low while in reset so every output reads 0 during reset.
  assign in_ready = reset && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == STREAM) && !empty;
  // The MAC result is stable on the last DRAIN cycle, so it is sampled there
  // and appears on result together with the result_valid pulse in DONE.
  assign capture  = (state == DRAIN) && (wait_cnt == LAST_WAIT);
  assign mac_clear = (state == CLEAR);
  assign busy      = (state != IDLE);

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  // FIFO pointers and occupancy; a pop only sees words written in earlier cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Operand register: popped pair lands here with a one-cycle strobe, otherwise held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_operand_a <= '0;
      mac_operand_b <= '0;
      mac_new_data  <= 1'b0;
    end else begin
      mac_new_data <= pop;
      if (pop) {mac_operand_a, mac_operand_b} <= mem[rd_ptr];
    end
  end

  // Pair counter for the frame and the post-stream MAC settle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == CLEAR)  count <= '0;
      else if (pop)        count <= count + CW'(1);
      if (state == DRAIN)  wait_cnt <= wait_cnt + WW'(1);
      else                 wait_cnt <= '0;
    end
  end

  // Result capture register and its one-cycle valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= capture;
      if (capture) result <= mac_acc_result;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = STREAM;
      STREAM:  if (pop && (count == LAST_CNT)) state_nxt = DRAIN;
      DRAIN:   if (wait_cnt == LAST_WAIT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_frame_sequencer.sv
// Directed bench for mac_frame_sequencer with a small behavioural MAC model.
// Expected values are hand-computed constants for ACC_CYCLES=4, MAC_LAT=2, FIFO_DEPTH=4.
module tb_mac_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_ready, mac_clear, mac_new_data, result_valid, busy;
  logic [7:0]  mac_operand_a, mac_operand_b;
  logic [24:0] mac_acc_result, result;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_clear, n_strobe, n_rv, rv_cyc, busy_drops, start_cyc;
  bit watch_busy = 1'b0;
  logic [15:0] strobe_q[$];
  int          strobe_cyc[$];
  logic [24:0] acc, acc_d;

  mac_frame_sequencer #(
    .BITWIDTH_A(8), .BITWIDTH_B(8), .ACC_CYCLES(4),
    .BITWIDTH_ACC(25), .FIFO_DEPTH(4), .MAC_LAT(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .mac_clear(mac_clear),
    .mac_new_data(mac_new_data), .mac_operand_a(mac_operand_a),
    .mac_operand_b(mac_operand_b), .mac_acc_result(mac_acc_result),
    .result(result), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // MAC model: accumulate on strobe, one extra output stage gives MAC_LAT=2.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      acc_d <= '0;
    end else begin
      if (mac_clear)         acc <= '0;
      else if (mac_new_data) acc <= acc + 25'(mac_operand_a) * 25'(mac_operand_b);
      acc_d <= acc;
    end
  end
  assign mac_acc_result = acc_d;

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      if (mac_clear) n_clear++;
      if (mac_new_data) begin
        n_strobe++;
        strobe_q.push_back({mac_operand_a, mac_operand_b});
        strobe_cyc.push_back(cyc);
      end
      if (result_valid) begin
        n_rv++;
        rv_cyc = cyc;
      end
      if (watch_busy && !busy) busy_drops++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr_mon();
    n_clear = 0; n_strobe = 0; n_rv = 0; rv_cyc = 0; busy_drops = 0;
    strobe_q.delete();
    strobe_cyc.delete();
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                           output bit ok, output int acc_cyc);
    ok = 1'b0; acc_cyc = -1;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; acc_cyc = cyc; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (result_valid) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, busy, mac_clear, mac_new_data, result_valid} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000", {in_ready, busy, mac_clear, mac_new_data, result_valid});
    end
    vectors++;
    if ({result, mac_operand_a, mac_operand_b} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset_data: got res=%0d a=%0d b=%0d want 0", result, mac_operand_a, mac_operand_b);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({in_ready, busy, mac_clear, mac_new_data, result_valid} !== 5'b10000) begin
      miscompares++;
      $display("FAIL idle_ctrl: got %b want 10000", {in_ready, busy, mac_clear, mac_new_data, result_valid});
    end
    vectors++;
    if (result !== 25'd0) begin
      miscompares++;
      $display("FAIL idle_result: got %0d want 0", result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_prefill();
    logic [7:0] ea[4] = '{8'd1, 8'd3, 8'd5, 8'd7};
    logic [7:0] eb[4] = '{8'd2, 8'd4, 8'd6, 8'd8};
    bit ok; int c;
    clr_mon();
    for (int i = 0; i < 4; i++) push_pair(ea[i], eb[i], ok, c);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL prefill_full: in_ready got %b want 0", in_ready);
    end
    pulse_start();
    wait_result(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL prefill_timeout: no result_valid"); end
    vectors++;
    if (result !== 25'd100) begin
      miscompares++;
      $display("FAIL prefill_result: got %0d want 100", result);
    end
    vectors++;
    if (rv_cyc - start_cyc !== 9) begin
      miscompares++;
      $display("FAIL prefill_latency: got %0d want 9", rv_cyc - start_cyc);
    end
    vectors++;
    if (n_clear !== 1 || n_strobe !== 4 || n_rv !== 1) begin
      miscompares++;
      $display("FAIL prefill_counts: clear=%0d strobe=%0d rv=%0d want 1 4 1", n_clear, n_strobe, n_rv);
    end
    vectors++;
    if (strobe_cyc.size() != 4 || strobe_cyc[3] - strobe_cyc[0] !== 3) begin
      miscompares++;
      $display("FAIL prefill_consecutive: strobes=%0d not in 4 back-to-back cycles", strobe_cyc.size());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (strobe_q.size() <= i || strobe_q[i] !== {ea[i], eb[i]}) begin
        miscompares++;
        $display("FAIL prefill_pair%0d: got %h want %h", i, (strobe_q.size() > i) ? strobe_q[i] : 16'hxxxx, {ea[i], eb[i]});
      end
    end
    @(negedge clk);
    vectors++;
    if ({busy, result_valid} !== 2'b00 || result !== 25'd100) begin
      miscompares++;
      $display("FAIL prefill_hold: busy=%b rv=%b res=%0d want 0 0 100", busy, result_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gapped();
    bit ok; int c;
    clr_mon();
    pulse_start();
    watch_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      repeat (3) @(posedge clk);
      #1;
      push_pair(8'(2 * i), 8'(2 * i + 1), ok, c);
    end
    wait_result(ok);
    watch_busy = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL gapped_timeout: no result_valid"); end
    vectors++;
    if (result !== 25'd140) begin
      miscompares++;
      $display("FAIL gapped_result: got %0d want 140", result);
    end
    vectors++;
    if (n_strobe !== 4 || n_clear !== 1 || n_rv !== 1) begin
      miscompares++;
      $display("FAIL gapped_counts: strobe=%0d clear=%0d rv=%0d want 4 1 1", n_strobe, n_clear, n_rv);
    end
    vectors++;
    if (busy_drops !== 0) begin
      miscompares++;
      $display("FAIL gapped_busy: busy dropped %0d times want 0", busy_drops);
    end
    vectors++;
    if ({mac_operand_a, mac_operand_b, mac_new_data} !== {8'd8, 8'd9, 1'b0}) begin
      miscompares++;
      $display("FAIL gapped_hold: a=%0d b=%0d nd=%b want 8 9 0", mac_operand_a, mac_operand_b, mac_new_data);
    end
  endtask

  task automatic test_overfill_ignore_start();
    bit ok; int c;
    logic [15:0] e;
    clr_mon();
    for (int i = 1; i <= 4; i++) push_pair(8'(i), 8'(i), ok, c);
    in_a = 8'd5; in_b = 8'd5; in_valid = 1'b1;
    pulse_start();
    @(negedge clk);
    vectors++;
    if ({in_ready, mac_clear, busy} !== 3'b011) begin
      miscompares++;
      $display("FAIL overfill_clear: rdy/clr/busy got %b want 011", {in_ready, mac_clear, busy});
    end
    push_pair(8'd5, 8'd5, ok, c);
    vectors++;
    if (!ok || c - start_cyc !== 3) begin
      miscompares++;
      $display("FAIL overfill_accept5: cycle offset got %0d want 3", c - start_cyc);
    end
    push_pair(8'd6, 8'd6, ok, c);
    pulse_start();
    wait_result(ok);
    vectors++;
    if (!ok || result !== 25'd30) begin
      miscompares++;
      $display("FAIL overfill_result1: got %0d want 30", result);
    end
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (n_clear !== 1 || n_rv !== 1 || n_strobe !== 4 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start: clear=%0d rv=%0d strobe=%0d busy=%b want 1 1 4 0", n_clear, n_rv, n_strobe, busy);
    end
    clr_mon();
    push_pair(8'd7, 8'd7, ok, c);
    push_pair(8'd8, 8'd8, ok, c);
    pulse_start();
    wait_result(ok);
    vectors++;
    if (!ok || result !== 25'd174) begin
      miscompares++;
      $display("FAIL overfill_result2: got %0d want 174", result);
    end
    e = {8'd5, 8'd5};
    vectors++;
    if (strobe_q.size() == 0 || strobe_q[0] !== e) begin
      miscompares++;
      $display("FAIL overfill_carry: first pair got %h want %h", (strobe_q.size() > 0) ? strobe_q[0] : 16'hxxxx, e);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok; int c;
    clr_mon();
    for (int i = 10; i <= 13; i++) push_pair(8'(i), 8'(i), ok, c);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (n_strobe >= 2) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL midreset_timeout: fewer than 2 strobes"); end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({in_ready, busy, mac_clear, mac_new_data, result_valid} !== 5'b00000 ||
        {result, mac_operand_a, mac_operand_b} !== 41'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: ctrl=%b res=%0d a=%0d b=%0d want all 0",
               {in_ready, busy, mac_clear, mac_new_data, result_valid}, result, mac_operand_a, mac_operand_b);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    clr_mon();
    pulse_start();
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (n_strobe !== 0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_flush: strobes=%0d busy=%b want 0 1", n_strobe, busy);
    end
    push_pair(8'd1, 8'd3, ok, c);
    push_pair(8'd2, 8'd4, ok, c);
    push_pair(8'd3, 8'd5, ok, c);
    push_pair(8'd4, 8'd6, ok, c);
    wait_result(ok);
    vectors++;
    if (!ok || result !== 25'd50 || n_strobe !== 4) begin
      miscompares++;
      $display("FAIL midreset_fresh: result=%0d strobes=%0d want 50 4", result, n_strobe);
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_gapped();
    test_overfill_ignore_start();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
